mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 reset  in  1  asynchronous, active-low; all state clears immediately on assertion, release sampled on clk.
REQ-003 es_to_ms_valid  in 1; es_to_ms_bus  in 169  from EXE. Fields: [168:165] tlbp/tlbr/tlbwi/tlbwr, [164:133] addr, [132:128] mfc0_rd, [127] ex, [126:122] ExcCode, [121] bd, [120] eret, [119:117] sel, [116] mtc0, [115] mfc0, [114:83] rt_value, [82:71] mem_inst, [70] res_from_mem, [69] gr_we, [68:64] dest, [63:32] alu_result, [31:0] pc.
REQ-004 mem_inst bit map: 0 lw, 1 sw, 2 lb, 3 lbu, 4 lh, 5 lhu, 6 lwl, 7 lwr, 8 sb, 9 sh, 10 swl, 11 swr.
REQ-005 ms_allowin  out 1  MEM can accept from EXE.
REQ-006 ws_allowin  in 1; ms_to_ws_valid  out 1; ms_to_ws_bus  out 127 = {ex, ExcCode[4:0], bd, eret, sel[2:0], mtc0, mfc0, mfc0_rd[4:0], tlb[3:0], badvaddr[31:0], rf_we[3:0], dest[4:0], result[31:0], pc[31:0]}, MSB first.
REQ-007 data_data_ok  in 1; data_rdata  in 32  DCache read return.
REQ-008 flush  in 1  discard MEM contents.
REQ-009 ms_ex  out 1; ms_inst_eret  out 1; ms_inst_mfc0  out 1  to EXE/ID.
REQ-010 MEM_dest  out 5; MEM_result  out 32; ms_load_pending  out 1  forwarding to ID.

Function
REQ-011 ms_valid set to es_to_ms_valid at each edge where ms_allowin=1; cleared at edge where flush=1 (flush priority).
REQ-012 Bus register captures es_to_ms_bus only when es_to_ms_valid && ms_allowin && !flush.
REQ-013 Read buffer: on any edge with data_data_ok=1, rdata_r<=data_rdata, rdata_vld<=1; otherwise rdata_vld<=0 at edges where (ms_to_ws_valid && ws_allowin) or flush. Set has priority over clear.
REQ-014 ms_ready_go = ex | !res_from_mem | rdata_vld.
REQ-015 ms_allowin = !ms_valid | (ms_ready_go & ws_allowin); ms_to_ws_valid = ms_valid & ms_ready_go.
REQ-016 Stall: with ws_allowin=0, bus register, rdata_r, all outputs hold.
REQ-017 Load data, a=addr[1:0], d=rdata_r: lw -> d; lb/lbu -> byte a, sign/zero extended; lh/lhu -> halfword a[1], sign/zero extended.
REQ-018 lwl: a=0 {d[7:0],rt[23:0]} strobe 1000; a=1 {d[15:0],rt[15:0]} 1100; a=2 {d[23:0],rt[7:0]} 1110; a=3 d 1111.
REQ-019 lwr: a=0 d 1111; a=1 {rt[31:24],d[31:8]} 0111; a=2 {rt[31:16],d[31:16]} 0011; a=3 {rt[31:8],d[31:24]} 0001.
REQ-020 result = load data if res_from_mem else alu_result; rf_we = strobe (1111 for non-lwl/lwr) when gr_we & !ex & ms_valid, else 0000.
REQ-021 badvaddr = addr when ExcCode is AdEL/AdES, else pc.
REQ-022 ms_ex = ms_valid & ex; ms_inst_eret = ms_valid & eret; ms_inst_mfc0 = ms_valid & mfc0.
REQ-023 MEM_dest = dest when ms_valid & gr_we, else 0; MEM_result = result; ms_load_pending = ms_valid & res_from_mem & !rdata_vld & !ex.
REQ-024 Excepting instruction: passes through without waiting for data; rf_we=0.

Reset
REQ-025 During reset: ms_valid=0, rdata_vld=0, rdata_r=0, bus register=0; hence ms_allowin=1, ms_to_ws_valid=0, ms_ex=0, ms_inst_eret=0, ms_inst_mfc0=0, MEM_dest=0, ms_load_pending=0.
REQ-026 Reset mid-stall discards held instruction and buffered data; first post-reset transfer behaves as from idle.

Verification
REQ-027 lb, addr=0x...2, data_data_ok with rdata=0x12_80_34_56 at entry edge, ws_allowin=1 -> next cycle ms_to_ws_valid=1, result=0xFFFFFF80, rf_we=1111.
REQ-028 lwl addr[1:0]=1, rt=0xAABBCCDD, rdata=0x11223344 -> result=0x3344CCDD, rf_we=1100; lwr same inputs -> 0xAA112233, 0111.
REQ-029 lw entered without data_ok, data_ok arrives 3 cycles later -> ms_load_pending=1 and ms_to_ws_valid=0 for 3 cycles, then ms_to_ws_valid=1 with rdata.
REQ-030 ws_allowin=0 for 4 cycles with valid lhu -> ms_allowin=0, bus and result stable; release -> single transfer, rdata_vld clears.
REQ-031 ex=1, ExcCode=AdEL, addr=0x1001 -> ms_ex=1, immediate transfer, rf_we=0000, badvaddr=0x1001; flush next edge -> ms_valid=0.
REQ-032 reset asserted asynchronously mid-stall -> all REQ-025 values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mem_stage.sv
// MEM pipeline stage: holds one instruction from EXE, waits for DCache read data
// on loads, aligns/extends load data and forwards the result to WB.
`timescale 1ns/1ps
module mem_stage (
  input  logic         clk,
  input  logic         reset,
  input  logic         es_to_ms_valid,
  input  logic [168:0] es_to_ms_bus,
  output logic         ms_allowin,
  input  logic         ws_allowin,
  output logic         ms_to_ws_valid,
  output logic [126:0] ms_to_ws_bus,
  input  logic         data_data_ok,
  input  logic [31:0]  data_rdata,
  input  logic         flush,
  output logic         ms_ex,
  output logic         ms_inst_eret,
  output logic         ms_inst_mfc0,
  output logic [4:0]   MEM_dest,
  output logic [31:0]  MEM_result,
  output logic         ms_load_pending
);

  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;

  logic         ms_valid_r;
  logic [168:0] bus_r;
  logic [31:0]  rdata_r;
  logic         rdata_vld_r;

  logic [3:0]   tlb_s;
  logic [31:0]  addr_s;
  logic [4:0]   mfc0_rd_s;
  logic         ex_s;
  logic [4:0]   exc_code_s;
  logic         bd_s;
  logic         eret_s;
  logic [2:0]   sel_s;
  logic         mtc0_s;
  logic         mfc0_s;
  logic [31:0]  rt_value_s;
  logic [11:0]  mem_inst_s;
  logic         res_from_mem_s;
  logic         gr_we_s;
  logic [4:0]   dest_s;
  logic [31:0]  alu_result_s;
  logic [31:0]  pc_s;

  logic         ms_ready_go_s;
  logic [3:0]   load_strobe_s;
  logic [31:0]  load_data_s;
  logic [31:0]  result_s;
  logic [3:0]   rf_we_s;
  logic [31:0]  badvaddr_s;
  logic         unused_mem_inst_s;

  // Aligns raw read data for one load; kind = mem_inst[7:2] (lb,lbu,lh,lhu,lwl,lwr).
  // Returns {byte strobe, merged value}; lw and anything else pass the word through.
  function automatic logic [35:0] align_load(input logic [5:0]  kind,
                                             input logic [1:0]  a,
                                             input logic [31:0] d,
                                             input logic [31:0] rt);
    logic [7:0]  b;
    logic [15:0] h;
    logic [3:0]  stb;
    logic [31:0] val;
    case (a)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    h   = a[1] ? d[31:16] : d[15:0];
    stb = 4'b1111;
    val = d;
    if (kind[0]) begin
      val = {{24{b[7]}}, b};
    end else if (kind[1]) begin
      val = {24'd0, b};
    end else if (kind[2]) begin
      val = {{16{h[15]}}, h};
    end else if (kind[3]) begin
      val = {16'd0, h};
    end else if (kind[4]) begin
      case (a)
        2'd0:    begin val = {d[7:0],  rt[23:0]}; stb = 4'b1000; end
        2'd1:    begin val = {d[15:0], rt[15:0]}; stb = 4'b1100; end
        2'd2:    begin val = {d[23:0], rt[7:0]};  stb = 4'b1110; end
        default: begin val = d;                   stb = 4'b1111; end
      endcase
    end else if (kind[5]) begin
      case (a)
        2'd0:    begin val = d;                      stb = 4'b1111; end
        2'd1:    begin val = {rt[31:24], d[31:8]};  stb = 4'b0111; end
        2'd2:    begin val = {rt[31:16], d[31:16]}; stb = 4'b0011; end
        default: begin val = {rt[31:8],  d[31:24]}; stb = 4'b0001; end
      endcase
    end else begin
      val = d;
      stb = 4'b1111;
    end
    return {stb, val};
  endfunction

  assign tlb_s          = bus_r[168:165];
  assign addr_s         = bus_r[164:133];
  assign mfc0_rd_s      = bus_r[132:128];
  assign ex_s           = bus_r[127];
  assign exc_code_s     = bus_r[126:122];
  assign bd_s           = bus_r[121];
  assign eret_s         = bus_r[120];
  assign sel_s          = bus_r[119:117];
  assign mtc0_s         = bus_r[116];
  assign mfc0_s         = bus_r[115];
  assign rt_value_s     = bus_r[114:83];
  assign mem_inst_s     = bus_r[82:71];
  assign res_from_mem_s = bus_r[70];
  assign gr_we_s        = bus_r[69];
  assign dest_s         = bus_r[68:64];
  assign alu_result_s   = bus_r[63:32];
  assign pc_s           = bus_r[31:0];

  // lw/sw and the store-only bits need no alignment here
  assign unused_mem_inst_s = ^{mem_inst_s[11:8], mem_inst_s[1:0]};

  assign ms_ready_go_s  = ex_s | ~res_from_mem_s | rdata_vld_r;
  assign ms_allowin     = ~ms_valid_r | (ms_ready_go_s & ws_allowin);
  assign ms_to_ws_valid = ms_valid_r & ms_ready_go_s;

  // Load alignment, writeback strobe and bad-address selection
  always_comb begin
    {load_strobe_s, load_data_s} = align_load(mem_inst_s[7:2], addr_s[1:0], rdata_r, rt_value_s);
    result_s = res_from_mem_s ? load_data_s : alu_result_s;
    if (gr_we_s && !ex_s && ms_valid_r) begin
      rf_we_s = load_strobe_s;
    end else begin
      rf_we_s = 4'b0000;
    end
    if (exc_code_s == EXC_ADEL || exc_code_s == EXC_ADES) begin
      badvaddr_s = addr_s;
    end else begin
      badvaddr_s = pc_s;
    end
  end

  assign ms_to_ws_bus = {ex_s, exc_code_s, bd_s, eret_s, sel_s, mtc0_s, mfc0_s, mfc0_rd_s,
                         tlb_s, badvaddr_s, rf_we_s, dest_s, result_s, pc_s};

  assign ms_ex           = ms_valid_r & ex_s;
  assign ms_inst_eret    = ms_valid_r & eret_s;
  assign ms_inst_mfc0    = ms_valid_r & mfc0_s;
  assign MEM_dest        = (ms_valid_r & gr_we_s) ? dest_s : 5'd0;
  assign MEM_result      = result_s;
  assign ms_load_pending = ms_valid_r & res_from_mem_s & ~rdata_vld_r & ~ex_s;

  // Stage valid bit; flush wins over a new acceptance
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ms_valid_r <= 1'b0;
    end else if (flush) begin
      ms_valid_r <= 1'b0;
    end else if (ms_allowin) begin
      ms_valid_r <= es_to_ms_valid;
    end else begin
      ms_valid_r <= ms_valid_r;
    end
  end

  // Instruction bus register, loaded only on an accepted, non-flushed handoff
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus_r <= 169'd0;
    end else if (es_to_ms_valid && ms_allowin && !flush) begin
      bus_r <= es_to_ms_bus;
    end else begin
      bus_r <= bus_r;
    end
  end

  // Read-data buffer: a returning beat is captured even if the same edge retires the load
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_r     <= 32'd0;
      rdata_vld_r <= 1'b0;
    end else if (data_data_ok) begin
      rdata_r     <= data_rdata;
      rdata_vld_r <= 1'b1;
    end else if ((ms_to_ws_valid && ws_allowin) || flush) begin
      rdata_r     <= rdata_r;
      rdata_vld_r <= 1'b0;
    end else begin
      rdata_r     <= rdata_r;
      rdata_vld_r <= rdata_vld_r;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: table of single-load vectors, hand-written multi-cycle
// sequences, then random traffic against a field-level reference model.
`timescale 1ns/1ps
module tb_mem_stage;

  typedef struct packed {
    logic [3:0]  tlb;
    logic [31:0] addr;
    logic [4:0]  mfc0_rd;
    logic        ex;
    logic [4:0]  exc;
    logic        bd;
    logic        eret;
    logic [2:0]  sel;
    logic        mtc0;
    logic        mfc0;
    logic [31:0] rt;
    logic [11:0] mi;
    logic        rfm;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu;
    logic [31:0] pc;
  } inst_t;

  typedef struct {
    string       name;
    logic [11:0] mi;
    logic [31:0] addr;
    logic [31:0] rt;
    logic [31:0] d;
    logic        rfm;
    logic        gr_we;
    logic [31:0] alu;
    logic [31:0] exp_res;
    logic [3:0]  exp_we;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         es_to_ms_valid;
  logic [168:0] es_to_ms_bus;
  logic         ms_allowin;
  logic         ws_allowin;
  logic         ms_to_ws_valid;
  logic [126:0] ms_to_ws_bus;
  logic         data_data_ok;
  logic [31:0]  data_rdata;
  logic         flush;
  logic         ms_ex;
  logic         ms_inst_eret;
  logic         ms_inst_mfc0;
  logic [4:0]   MEM_dest;
  logic [31:0]  MEM_result;
  logic         ms_load_pending;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  logic        m_v;
  inst_t       m_i;
  logic [31:0] m_d;
  logic        m_dv;

  mem_stage dut (
    .clk(clk), .reset(reset),
    .es_to_ms_valid(es_to_ms_valid), .es_to_ms_bus(es_to_ms_bus),
    .ms_allowin(ms_allowin), .ws_allowin(ws_allowin),
    .ms_to_ws_valid(ms_to_ws_valid), .ms_to_ws_bus(ms_to_ws_bus),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata), .flush(flush),
    .ms_ex(ms_ex), .ms_inst_eret(ms_inst_eret), .ms_inst_mfc0(ms_inst_mfc0),
    .MEM_dest(MEM_dest), .MEM_result(MEM_result), .ms_load_pending(ms_load_pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic inst_t mk(input logic [11:0] mi, input logic [31:0] addr, input logic [31:0] rt,
                               input logic rfm, input logic gr_we, input logic [31:0] alu);
    inst_t i;
    i = '0;
    i.mi = mi; i.addr = addr; i.rt = rt; i.rfm = rfm; i.gr_we = gr_we; i.alu = alu;
    i.dest = 5'd9;
    i.pc = 32'hBFC0_0100;
    return i;
  endfunction

  // Load value and strobe from the architectural rules, via shifts and masks
  function automatic logic [35:0] ref_load(input inst_t i, input logic [31:0] d);
    int          a;
    int          sh;
    logic [7:0]  bv;
    logic [15:0] hv;
    logic [31:0] one;
    logic [31:0] val;
    logic [3:0]  stb;
    a   = int'(i.addr[1:0]);
    one = 32'd1;
    bv  = 8'(d >> (8 * a));
    hv  = 16'(d >> (16 * (a / 2)));
    stb = 4'b1111;
    val = d;
    if (i.mi[2])      val = {{24{bv[7]}}, bv};
    else if (i.mi[3]) val = {24'd0, bv};
    else if (i.mi[4]) val = {{16{hv[15]}}, hv};
    else if (i.mi[5]) val = {16'd0, hv};
    else if (i.mi[6]) begin
      sh  = 8 * (3 - a);
      val = (d << sh) | (i.rt & ((one << sh) - 32'd1));
      stb = 4'(4'b1111 << (3 - a));
    end else if (i.mi[7]) begin
      sh  = 8 * a;
      val = (d >> sh) | (i.rt & ~(32'hFFFF_FFFF >> sh));
      stb = 4'(4'b1111 >> a);
    end
    return {stb, val};
  endfunction

  // Expected {allowin, to_ws_valid, ws_bus, ex, eret, mfc0, dest, result, pending}
  function automatic logic [169:0] ref_out(input logic v, input inst_t i, input logic [31:0] d,
                                           input logic dv, input logic ws);
    logic        rdy;
    logic [35:0] ld;
    logic [31:0] res;
    logic [3:0]  we;
    logic [31:0] bad;
    logic [126:0] wb;
    rdy = i.ex | ~i.rfm | dv;
    ld  = ref_load(i, d);
    res = i.rfm ? ld[31:0] : i.alu;
    we  = (i.gr_we && !i.ex && v) ? ld[35:32] : 4'b0000;
    bad = (i.exc == 5'd4 || i.exc == 5'd5) ? i.addr : i.pc;
    wb  = {i.ex, i.exc, i.bd, i.eret, i.sel, i.mtc0, i.mfc0, i.mfc0_rd, i.tlb, bad, we, i.dest, res, i.pc};
    return {(~v | (rdy & ws)), (v & rdy), wb, (v & i.ex), (v & i.eret), (v & i.mfc0),
            ((v & i.gr_we) ? i.dest : 5'd0), res, (v & i.rfm & ~dv & ~i.ex)};
  endfunction

  task automatic model_step(input logic esv, input inst_t ni, input logic ws, input logic dok,
                            input logic [31:0] rd, input logic fl);
    logic rdy;
    logic alw;
    logic tv;
    rdy = m_i.ex | ~m_i.rfm | m_dv;
    alw = ~m_v | (rdy & ws);
    tv  = m_v & rdy;
    if (esv && alw && !fl) m_i = ni;
    m_v = fl ? 1'b0 : (alw ? esv : m_v);
    if (dok) begin m_d = rd; m_dv = 1'b1; end
    else if ((tv && ws) || fl) m_dv = 1'b0;
  endtask

  function automatic inst_t rand_inst();
    inst_t i;
    int    k;
    i = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    k = $urandom_range(0, 12);
    i.mi = 12'd0;
    if (k <= 6) begin
      case (k)
        0: i.mi[0] = 1'b1;
        1: i.mi[2] = 1'b1;
        2: i.mi[3] = 1'b1;
        3: i.mi[4] = 1'b1;
        4: i.mi[5] = 1'b1;
        5: i.mi[6] = 1'b1;
        default: i.mi[7] = 1'b1;
      endcase
      i.rfm = 1'b1;
    end else begin
      if (k <= 9) i.mi[8 + k - 7] = 1'b1;
      i.rfm = 1'b0;
    end
    i.ex = ($urandom_range(0, 9) == 0);
    k = $urandom_range(0, 2);
    i.exc = (k == 0) ? 5'd4 : ((k == 1) ? 5'd5 : 5'($urandom_range(0, 31)));
    return i;
  endfunction

  task automatic idle();
    es_to_ms_valid = 1'b0;
    data_data_ok   = 1'b0;
    flush          = 1'b0;
    ws_allowin     = 1'b1;
  endtask

  vec_t  vecs[13];
  inst_t ti;
  logic [169:0] exp_o;

  initial begin
    vecs[0]  = '{"lb_a2",     12'h004, 32'h0000_1002, 32'h0,         32'h1280_3456, 1'b1, 1'b1, 32'h0,         32'hFFFF_FF80, 4'b1111};
    vecs[1]  = '{"lbu_a2",    12'h008, 32'h0000_1002, 32'h0,         32'h1280_3456, 1'b1, 1'b1, 32'h0,         32'h0000_0080, 4'b1111};
    vecs[2]  = '{"lh_a2",     12'h010, 32'h0000_2002, 32'h0,         32'h8001_3456, 1'b1, 1'b1, 32'h0,         32'hFFFF_8001, 4'b1111};
    vecs[3]  = '{"lhu_a0",    12'h020, 32'h0000_2000, 32'h0,         32'h1234_F00D, 1'b1, 1'b1, 32'h0,         32'h0000_F00D, 4'b1111};
    vecs[4]  = '{"lw",        12'h001, 32'h0000_3000, 32'h0,         32'h1122_3344, 1'b1, 1'b1, 32'h0,         32'h1122_3344, 4'b1111};
    vecs[5]  = '{"lwl_a1",    12'h040, 32'h0000_3001, 32'hAABB_CCDD, 32'h1122_3344, 1'b1, 1'b1, 32'h0,         32'h3344_CCDD, 4'b1100};
    vecs[6]  = '{"lwr_a1",    12'h080, 32'h0000_3001, 32'hAABB_CCDD, 32'h1122_3344, 1'b1, 1'b1, 32'h0,         32'hAA11_2233, 4'b0111};
    vecs[7]  = '{"lwl_a0",    12'h040, 32'h0000_3000, 32'hAABB_CCDD, 32'h1122_3344, 1'b1, 1'b1, 32'h0,         32'h44BB_CCDD, 4'b1000};
    vecs[8]  = '{"lwr_a3",    12'h080, 32'h0000_3003, 32'hAABB_CCDD, 32'h1122_3344, 1'b1, 1'b1, 32'h0,         32'hAABB_CC11, 4'b0001};
    vecs[9]  = '{"lwl_a3",    12'h040, 32'h0000_3003, 32'hAABB_CCDD, 32'h1122_3344, 1'b1, 1'b1, 32'h0,         32'h1122_3344, 4'b1111};
    vecs[10] = '{"alu",       12'h000, 32'h0000_0000, 32'h0,         32'h5555_5555, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'b1111};
    vecs[11] = '{"lw_no_we",  12'h001, 32'h0000_3000, 32'h0,         32'h1122_3344, 1'b1, 1'b0, 32'h0,         32'h1122_3344, 4'b0000};
    vecs[12] = '{"lb_a3_pos", 12'h004, 32'h0000_1003, 32'h0,         32'h7F00_0000, 1'b1, 1'b1, 32'h0,         32'h0000_007F, 4'b1111};

    reset = 1'b0;
    idle();
    es_to_ms_bus = '0;
    data_rdata   = 32'd0;
    #12;
    check("rst_allowin", 256'(ms_allowin), 256'(1'b1));
    check("rst_outs", 256'({ms_to_ws_valid, ms_ex, ms_inst_eret, ms_inst_mfc0, MEM_dest, ms_load_pending}), 256'd0);
    @(negedge clk);
    reset = 1'b1;

    // single loads whose data returns on the entry edge
    for (int v = 0; v < 13; v++) begin
      es_to_ms_valid = 1'b1;
      es_to_ms_bus   = mk(vecs[v].mi, vecs[v].addr, vecs[v].rt, vecs[v].rfm, vecs[v].gr_we, vecs[v].alu);
      data_data_ok   = 1'b1;
      data_rdata     = vecs[v].d;
      ws_allowin     = 1'b1;
      tick();
      es_to_ms_valid = 1'b0;
      data_data_ok   = 1'b0;
      #1;
      check({vecs[v].name, "_valid"},  256'(ms_to_ws_valid), 256'(1'b1));
      check({vecs[v].name, "_result"}, 256'(ms_to_ws_bus[63:32]), 256'(vecs[v].exp_res));
      check({vecs[v].name, "_rf_we"},  256'(ms_to_ws_bus[72:69]), 256'(vecs[v].exp_we));
      check({vecs[v].name, "_fwd"},    256'({MEM_result, MEM_dest}),
            256'({vecs[v].exp_res, (vecs[v].gr_we ? 5'd9 : 5'd0)}));
      tick();
    end

    // lw whose data returns three cycles after entry
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk(12'h001, 32'h0000_4000, 32'h0, 1'b1, 1'b1, 32'h0);
    tick();
    es_to_ms_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("late_pending", 256'({ms_load_pending, ms_to_ws_valid}), 256'(2'b10));
      if (k == 2) begin
        data_data_ok = 1'b1;
        data_rdata   = 32'hCAFE_F00D;
      end
      tick();
    end
    data_data_ok = 1'b0;
    #1;
    check("late_done", 256'({ms_load_pending, ms_to_ws_valid, ms_to_ws_bus[63:32]}), 256'({2'b01, 32'hCAFE_F00D}));
    tick();

    // lhu held by WB back-pressure for four cycles
    ti = mk(12'h020, 32'h0000_5002, 32'h0, 1'b1, 1'b1, 32'h0);
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = ti;
    data_data_ok   = 1'b1;
    data_rdata     = 32'h8001_1234;
    ws_allowin     = 1'b0;
    tick();
    data_data_ok   = 1'b0;
    data_rdata     = 32'h9999_9999;
    es_to_ms_bus   = mk(12'h001, 32'h0000_6000, 32'h0, 1'b1, 1'b1, 32'h0);
    exp_o = ref_out(1'b1, ti, 32'h8001_1234, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      #1;
      check("stall_ctl", 256'({ms_allowin, ms_to_ws_valid}), 256'(2'b01));
      check("stall_bus", 256'(ms_to_ws_bus), 256'(exp_o[167:41]));
      check("stall_res", 256'(MEM_result), 256'(32'h0000_8001));
      tick();
    end
    ws_allowin     = 1'b1;
    es_to_ms_valid = 1'b0;
    tick();
    check("release_once", 256'({ms_to_ws_valid, ms_allowin}), 256'(2'b01));
    es_to_ms_valid = 1'b1;
    tick();
    es_to_ms_valid = 1'b0;
    #1;
    check("release_vld_clr", 256'(ms_load_pending), 256'(1'b1));
    flush = 1'b1;
    tick();
    flush = 1'b0;

    // AdEL exception: passes without data, then is flushed
    ti = mk(12'h001, 32'h0000_1001, 32'h0, 1'b1, 1'b1, 32'h0);
    ti.ex  = 1'b1;
    ti.exc = 5'd4;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = ti;
    tick();
    es_to_ms_valid = 1'b0;
    #1;
    check("ex_pass", 256'({ms_ex, ms_to_ws_valid, ms_load_pending}), 256'(3'b110));
    check("ex_rf_we", 256'(ms_to_ws_bus[72:69]), 256'(4'b0000));
    check("ex_badvaddr", 256'(ms_to_ws_bus[104:73]), 256'(32'h0000_1001));
    flush      = 1'b1;
    ws_allowin = 1'b0;
    tick();
    flush      = 1'b0;
    ws_allowin = 1'b1;
    #1;
    check("ex_flushed", 256'({ms_ex, ms_to_ws_valid, ms_allowin}), 256'(3'b001));

    // asynchronous reset in the middle of a stall
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk(12'h001, 32'h0000_7000, 32'h0, 1'b1, 1'b1, 32'h0);
    ws_allowin     = 1'b0;
    tick();
    es_to_ms_valid = 1'b0;
    tick();
    #1;
    check("pre_rst_pending", 256'(ms_load_pending), 256'(1'b1));
    #1;
    reset = 1'b0;
    #1;
    check("async_rst", 256'({ms_allowin, ms_to_ws_valid, ms_ex, ms_inst_eret, ms_inst_mfc0, MEM_dest, ms_load_pending}),
          256'({1'b1, 10'd0}));
    check("async_rst_bus", 256'(ms_to_ws_bus), 256'd0);
    @(negedge clk);
    reset = 1'b1;
    idle();
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk(12'h004, 32'h0000_1002, 32'h0, 1'b1, 1'b1, 32'h0);
    data_data_ok   = 1'b1;
    data_rdata     = 32'h1280_3456;
    tick();
    idle();
    #1;
    check("post_rst_lb", 256'({ms_to_ws_valid, ms_to_ws_bus[72:69], ms_to_ws_bus[63:32]}),
          256'({1'b1, 4'b1111, 32'hFFFF_FF80}));
    tick();

    // random traffic against the reference model
    reset = 1'b0;
    #3;
    m_v = 1'b0; m_i = '0; m_d = 32'd0; m_dv = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      es_to_ms_valid = ($urandom_range(0, 9) < 7);
      es_to_ms_bus   = rand_inst();
      ws_allowin     = ($urandom_range(0, 9) < 7);
      data_data_ok   = ($urandom_range(0, 9) < 4);
      data_rdata     = $urandom;
      flush          = ($urandom_range(0, 19) == 0);
      #1;
      exp_o = ref_out(m_v, m_i, m_d, m_dv, ws_allowin);
      check("random", 256'({ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_ex, ms_inst_eret, ms_inst_mfc0,
                            MEM_dest, MEM_result, ms_load_pending}), 256'(exp_o));
      model_step(es_to_ms_valid, es_to_ms_bus, ws_allowin, data_data_ok, data_rdata, flush);
      @(posedge clk);
      #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
